// File: rtl/raw_word_packer.sv
`default_nettype none
// ============================================================================
//  Module     : raw_word_packer
//  Description: Packs an 8-bit RAW Bayer pixel stream into 32-bit words and
//               drives write address/enable for port A of the frame buffer.
//               Tracks frame boundaries, wraps the word address after the
//               last word of a frame and gates capture at frame start.
//  Revision   : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters :
//    WORDS_PER_FRAME  32-bit words per frame (frame pixels / 4)
//    ADDR_W           word address width, 2**ADDR_W >= WORDS_PER_FRAME
//  Ports :
//    clk          in   system clock, rising edge
//    reset        in   asynchronous reset, active low
//    capture_en   in   1 = frames may be written (sampled at frame start)
//    frame_start  in   one-cycle pulse, start of a new frame
//    pix_valid    in   pix_data valid this cycle
//    pix_data     in   [7:0] RAW pixel byte
//    wr_data      out  [31:0] packed word to RAM port A
//    wr_addr      out  [ADDR_W-1:0] word address to RAM port A
//    wr_en        out  one-cycle write strobe
//    frame_done   out  pulse with the final write of a frame
//    frame_err    out  pulse one cycle after a frame was aborted short
//  Configuration macro :
//    RAW_PACK_MSB_FIRST_EN  defined -> first byte of a group lands in
//                           wr_data[31:24]; default -> first byte in [7:0]
// ============================================================================
module raw_word_packer #(
    parameter int WORDS_PER_FRAME = 76800,
    parameter int ADDR_W          = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture_en,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [7:0]        pix_data,
    output logic [31:0]       wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_en,
    output logic              frame_done,
    output logic              frame_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS_PER_FRAME - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [2:0][7:0]   lanes_q, lanes_d;        // first three bytes of a group
    logic [ADDR_W-1:0] next_addr_q, next_addr_d; // address of the next word
    logic [31:0]       wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              wr_en_q, wr_en_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q, frame_err_d;

    // Effective byte lane / address / acceptance after frame_start has been
    // applied, so a byte arriving with frame_start becomes lane 0 of word 0.
    logic              accept;
    logic [1:0]        cnt_eff;
    logic [ADDR_W-1:0] addr_eff;

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        lanes_d      = lanes_q;
        next_addr_d  = next_addr_q;
        wr_data_d    = wr_data_q;
        wr_addr_d    = wr_addr_q;
        wr_en_d      = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        accept       = (state_q == ST_ACTIVE);
        cnt_eff      = byte_cnt_q;
        addr_eff     = next_addr_q;

        if (frame_start) begin
            // A frame_start while still collecting means the frame was short.
            frame_err_d = (state_q == ST_ACTIVE);
            state_d     = capture_en ? ST_ACTIVE : ST_IDLE;
            accept      = capture_en;
            cnt_eff     = 2'd0;
            addr_eff    = '0;
            byte_cnt_d  = 2'd0;
            next_addr_d = '0;
        end

        if (accept && pix_valid) begin
            if (cnt_eff == 2'd3) begin
`ifdef RAW_PACK_MSB_FIRST_EN
                wr_data_d = {lanes_q[0], lanes_q[1], lanes_q[2], pix_data};
`else
                wr_data_d = {pix_data, lanes_q[2], lanes_q[1], lanes_q[0]};
`endif
                wr_en_d    = 1'b1;
                wr_addr_d  = addr_eff;
                byte_cnt_d = 2'd0;
                if (addr_eff == LAST_ADDR) begin
                    frame_done_d = 1'b1;
                    next_addr_d  = '0;
                    state_d      = ST_DONE;
                end else begin
                    next_addr_d  = addr_eff + ADDR_W'(1);
                end
            end else begin
                case (cnt_eff)
                    2'd0:    lanes_d[0] = pix_data;
                    2'd1:    lanes_d[1] = pix_data;
                    2'd2:    lanes_d[2] = pix_data;
                    default: lanes_d    = lanes_q;
                endcase
                byte_cnt_d = cnt_eff + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= 2'd0;
            lanes_q      <= '0;
            next_addr_q  <= '0;
            wr_data_q    <= '0;
            wr_addr_q    <= '0;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            lanes_q      <= lanes_d;
            next_addr_q  <= next_addr_d;
            wr_data_q    <= wr_data_d;
            wr_addr_q    <= wr_addr_d;
            wr_en_q      <= wr_en_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign wr_data    = wr_data_q;
    assign wr_addr    = wr_addr_q;
    assign wr_en      = wr_en_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_raw_word_packer.sv
`default_nettype none
// ============================================================================
//  Module     : tb_raw_word_packer
//  Description: Self-checking bench for raw_word_packer with a small frame
//               size. A frame-level reference model turns the applied byte
//               stream into the list of expected writes and error pulses.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_raw_word_packer;

    localparam int WPF = 48;
    localparam int AW  = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          capture_en = 1'b0;
    logic          frame_start = 1'b0;
    logic          pix_valid = 1'b0;
    logic [7:0]    pix_data = 8'h00;
    logic [31:0]   wr_data;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic          frame_done;
    logic          frame_err;

    raw_word_packer #(.WORDS_PER_FRAME(WPF), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .capture_en(capture_en),
        .frame_start(frame_start), .pix_valid(pix_valid), .pix_data(pix_data),
        .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic          dn;
    } wr_t;

    wr_t act_q[$];
    wr_t exp_q[$];
    int  act_err = 0, exp_err = 0, act_done = 0, exp_done = 0;
    int  n_vec = 0, n_err = 0;

    // reference model state: collecting or not, bytes of the current group,
    // index of the next word in the frame
    bit         m_active = 1'b0;
    logic [7:0] m_bytes[$];
    int         m_word = 0;

    always @(posedge clk) begin
        #1;
        if (wr_en) act_q.push_back('{a: wr_addr, d: wr_data, dn: frame_done});
        if (frame_err) act_err++;
        if (frame_done) act_done++;
    end

    function automatic logic [31:0] pack4(input logic [7:0] b0, b1, b2, b3);
`ifdef RAW_PACK_MSB_FIRST_EN
        return {b0, b1, b2, b3};
`else
        return {b3, b2, b1, b0};
`endif
    endfunction

    task automatic cyc(input logic fs, input logic pv, input logic [7:0] d);
        wr_t w;
        frame_start = fs;
        pix_valid   = pv;
        pix_data    = d;
        if (fs) begin
            if (m_active) exp_err++;
            m_bytes.delete();
            m_word   = 0;
            m_active = capture_en;
        end
        if (pv && m_active) begin
            m_bytes.push_back(d);
            if (m_bytes.size() == 4) begin
                w.a  = AW'(m_word);
                w.d  = pack4(m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]);
                w.dn = (m_word == WPF - 1);
                exp_q.push_back(w);
                m_bytes.delete();
                if (w.dn) begin
                    exp_done++;
                    m_active = 1'b0;
                    m_word   = 0;
                end else begin
                    m_word++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        frame_start = 1'b0;
        pix_valid   = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++; if (wr_data !== 32'h0) begin n_err++; $display("FAIL reset wr_data: got %h want 0", wr_data); end
        n_vec++; if (wr_addr !== '0) begin n_err++; $display("FAIL reset wr_addr: got %0d want 0", wr_addr); end
        n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset wr_en: got %b want 0", wr_en); end
        n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset frame_done: got %b want 0", frame_done); end
        n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset frame_err: got %b want 0", frame_err); end
    endtask

    task automatic test_first_word();
        logic [31:0] want;
`ifdef RAW_PACK_MSB_FIRST_EN
        want = 32'h11223344;
`else
        want = 32'h44332211;
`endif
        act_q.delete(); exp_q.delete();
        capture_en = 1'b1;
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h11);
        cyc(1'b0, 1'b1, 8'h22);
        cyc(1'b0, 1'b1, 8'h33);
        n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL first_word early wr_en: got %b want 0", wr_en); end
        cyc(1'b0, 1'b1, 8'h44);
        n_vec++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL first_word wr_en: got %b want 1", wr_en); end
        n_vec++; if (wr_addr !== '0) begin n_err++; $display("FAIL first_word wr_addr: got %0d want 0", wr_addr); end
        n_vec++; if (wr_data !== want) begin n_err++; $display("FAIL first_word wr_data: got %h want %h", wr_data, want); end
        cyc(1'b0, 1'b0, 8'h00);
        n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL first_word strobe width: got %b want 0", wr_en); end
    endtask

    task automatic test_full_frame();
        logic [7:0] base;
        int done0;
        base  = 8'($urandom);
        done0 = act_done;
        act_q.delete(); exp_q.delete();
        capture_en = 1'b1;
        cyc(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < WPF * 4; i++) begin
            if ($urandom_range(0, 3) == 0) cyc(1'b0, 1'b0, 8'h00);
            cyc(1'b0, 1'b1, base + 8'(i));
        end
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 8'($urandom));
        cyc(1'b0, 1'b0, 8'h00);
        n_vec++; if (act_q.size() != WPF) begin n_err++; $display("FAIL full_frame count: got %0d want %0d", act_q.size(), WPF); end
        n_vec++; if (act_q.size() != exp_q.size()) begin n_err++; $display("FAIL full_frame model count: got %0d want %0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            n_vec++;
            if (act_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL full_frame write %0d: got a=%0d d=%h dn=%b want a=%0d d=%h dn=%b",
                         i, act_q[i].a, act_q[i].d, act_q[i].dn, exp_q[i].a, exp_q[i].d, exp_q[i].dn);
            end
        end
        n_vec++; if (act_done - done0 != 1) begin n_err++; $display("FAIL full_frame done pulses: got %0d want 1", act_done - done0); end
        n_vec++; if (act_err != exp_err) begin n_err++; $display("FAIL full_frame err pulses: got %0d want %0d", act_err, exp_err); end
    endtask

    task automatic test_short_frame();
        int err0;
        err0 = act_err;
        act_q.delete(); exp_q.delete();
        capture_en = 1'b1;
        cyc(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 8'($urandom));
        cyc(1'b1, 1'b0, 8'h00);
        n_vec++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL short_frame frame_err: got %b want 1", frame_err); end
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'($urandom));
        cyc(1'b0, 1'b0, 8'h00);
        n_vec++; if (act_q.size() != 2 || exp_q.size() != 2) begin n_err++; $display("FAIL short_frame count: got %0d want 2", act_q.size()); end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            n_vec++;
            if (act_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL short_frame write %0d: got a=%0d d=%h want a=%0d d=%h",
                         i, act_q[i].a, act_q[i].d, exp_q[i].a, exp_q[i].d);
            end
        end
        n_vec++; if (act_err - err0 != 1) begin n_err++; $display("FAIL short_frame err pulses: got %0d want 1", act_err - err0); end
    endtask

    task automatic test_capture_off();
        act_q.delete(); exp_q.delete();
        capture_en = 1'b0;
        cyc(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < WPF * 4; i++) begin
            if (i == WPF * 2) capture_en = 1'b1;
            cyc(1'b0, 1'b1, 8'($urandom));
        end
        cyc(1'b0, 1'b0, 8'h00);
        n_vec++; if (act_q.size() != 0) begin n_err++; $display("FAIL capture_off writes: got %0d want 0", act_q.size()); end
        n_vec++; if (act_err != exp_err) begin n_err++; $display("FAIL capture_off err pulses: got %0d want %0d", act_err, exp_err); end
    endtask

    task automatic test_coincident();
        logic [31:0] want;
`ifdef RAW_PACK_MSB_FIRST_EN
        want = 32'hAABBCCDD;
`else
        want = 32'hDDCCBBAA;
`endif
        act_q.delete(); exp_q.delete();
        capture_en = 1'b1;
        cyc(1'b1, 1'b1, 8'hAA);
        cyc(1'b0, 1'b1, 8'hBB);
        cyc(1'b0, 1'b1, 8'hCC);
        cyc(1'b0, 1'b1, 8'hDD);
        n_vec++; if (wr_en !== 1'b1 || wr_addr !== '0 || wr_data !== want) begin
            n_err++; $display("FAIL coincident: got en=%b a=%0d d=%h want en=1 a=0 d=%h", wr_en, wr_addr, wr_data, want);
        end
        n_vec++; if (act_q.size() != 1) begin n_err++; $display("FAIL coincident count: got %0d want 1", act_q.size()); end
    endtask

    task automatic test_reset_mid();
        int err0;
        act_q.delete(); exp_q.delete();
        capture_en = 1'b1;
        cyc(1'b1, 1'b0, 8'h00);
        err0 = act_err;
        cyc(1'b0, 1'b1, 8'h5A);
        cyc(1'b0, 1'b1, 8'hA5);
        reset = 1'b0;
        m_active = 1'b0; m_bytes.delete(); m_word = 0;
        #1;
        n_vec++; if (wr_data !== 32'h0 || wr_addr !== '0 || wr_en !== 1'b0 || frame_done !== 1'b0 || frame_err !== 1'b0) begin
            n_err++; $display("FAIL reset_mid outputs: got d=%h a=%0d en=%b dn=%b er=%b want all 0",
                              wr_data, wr_addr, wr_en, frame_done, frame_err);
        end
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 8'($urandom));
        cyc(1'b0, 1'b0, 8'h00);
        n_vec++; if (act_q.size() != 0) begin n_err++; $display("FAIL reset_mid writes: got %0d want 0", act_q.size()); end
        n_vec++; if (act_err != err0) begin n_err++; $display("FAIL reset_mid frame_err: got %0d pulses want 0", act_err - err0); end
    endtask

    task automatic test_random();
        act_q.delete(); exp_q.delete();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) capture_en = ~capture_en;
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
        end
        cyc(1'b0, 1'b0, 8'h00);
        n_vec++; if (act_q.size() != exp_q.size()) begin n_err++; $display("FAIL random count: got %0d want %0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            n_vec++;
            if (act_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL random write %0d: got a=%0d d=%h dn=%b want a=%0d d=%h dn=%b",
                         i, act_q[i].a, act_q[i].d, act_q[i].dn, exp_q[i].a, exp_q[i].d, exp_q[i].dn);
            end
        end
        n_vec++; if (act_err != exp_err) begin n_err++; $display("FAIL random err pulses: got %0d want %0d", act_err, exp_err); end
        n_vec++; if (act_done != exp_done) begin n_err++; $display("FAIL random done pulses: got %0d want %0d", act_done, exp_done); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b1;
        @(negedge clk);
        test_first_word();
        test_full_frame();
        test_short_frame();
        test_capture_off();
        test_coincident();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
